// File: rtl/cursor_cell_ctrl_pkg.sv
// Shared constants for the TicTacToe board cursor: anchor pixels,
// cell boundaries for the position-to-cell mapper, FSM state encoding.
package cursor_cell_ctrl_pkg;

    localparam int IDX_W  = 2;
    localparam int CELL_W = 4;
    localparam int PIX_W  = 10;

    // Anchor pixels per column / row (inverse of the position-to-cell map)
    localparam logic [PIX_W-1:0] COL_X [3] = '{10'd91, 10'd305, 10'd518};
    localparam logic [PIX_W-1:0] ROW_Y [3] = '{10'd61, 10'd221, 10'd384};
    localparam logic [PIX_W-1:0] ROW_C [3] = '{10'd111, 10'd271, 10'd434};

    // Cell boundaries used by the position-to-cell mapper
    localparam logic [PIX_W-1:0] COL_B0 = 10'd214;
    localparam logic [PIX_W-1:0] COL_B1 = 10'd424;
    localparam logic [PIX_W-1:0] ROW_B0 = 10'd155;
    localparam logic [PIX_W-1:0] ROW_B1 = 10'd316;

    // FSM state encoding (kept as plain constants for legacy tools)
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_REQ  = 1'b1;

    // Linear cell index row*3+col without a multiplier
    function automatic logic [CELL_W-1:0] cell_idx(input logic [IDX_W-1:0] row,
                                                   input logic [IDX_W-1:0] col);
        return {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
    endfunction

endpackage

// File: rtl/cursor_cell_ctrl_if.sv
// Move-request handshake between the cursor controller and the game logic.
interface cursor_cell_ctrl_if;
    import cursor_cell_ctrl_pkg::*;

    logic              req_valid;
    logic [CELL_W-1:0] req_cell;
    logic              req_ready;

    modport master (output req_valid, output req_cell, input req_ready);
    modport slave  (input req_valid, input req_cell, output req_ready);

endinterface

// File: rtl/cursor_cell_ctrl_cell_anchor_lut.sv
// Pure index-to-pixel lookup; the parent registers the outputs.
module cell_anchor_lut
    import cursor_cell_ctrl_pkg::*;
(
    input  logic [IDX_W-1:0] i_row,
    input  logic [IDX_W-1:0] i_col,
    output logic [PIX_W-1:0] o_x,
    output logic [PIX_W-1:0] o_y,
    output logic [PIX_W-1:0] o_c
);

    // Column index selects the x anchor; index 3 never occurs, fold it to 0
    always_comb begin
        case (i_col)
            2'd1:    o_x = COL_X[1];
            2'd2:    o_x = COL_X[2];
            default: o_x = COL_X[0];
        endcase
    end

    // Row index selects the y anchor and the row centre
    always_comb begin
        case (i_row)
            2'd1: begin
                o_y = ROW_Y[1];
                o_c = ROW_C[1];
            end
            2'd2: begin
                o_y = ROW_Y[2];
                o_c = ROW_C[2];
            end
            default: begin
                o_y = ROW_Y[0];
                o_c = ROW_C[0];
            end
        endcase
    end

endmodule

// File: rtl/cursor_cell_ctrl.sv
// Board cursor for the 3x3 grid: moves on direction pulses, drives
// registered anchor pixels, and issues move requests on select.
module cursor_cell_ctrl
    import cursor_cell_ctrl_pkg::*;
#(
    parameter bit WRAP      = 1'b1,
    parameter int START_ROW = 1,
    parameter int START_COL = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_btn_up,
    input  logic               i_btn_down,
    input  logic               i_btn_left,
    input  logic               i_btn_right,
    input  logic               i_btn_sel,
    input  logic [8:0]         i_occupied,
    output logic [IDX_W-1:0]   o_cur_row,
    output logic [IDX_W-1:0]   o_cur_col,
    output logic [PIX_W-1:0]   o_anchor_x,
    output logic [PIX_W-1:0]   o_anchor_y,
    output logic [PIX_W-1:0]   o_anchor_c,
    output logic               o_reject,
    cursor_cell_ctrl_if.master req_if
);

    localparam logic [IDX_W-1:0] START_R = IDX_W'(START_ROW);
    localparam logic [IDX_W-1:0] START_C = IDX_W'(START_COL);

    state_t            r_state;
    logic [IDX_W-1:0]  r_row, r_col;
    logic [PIX_W-1:0]  r_ax, r_ay, r_ac;
    logic              r_reject;
    logic [CELL_W-1:0] r_req_cell;

    logic [3:0]        w_dir;
    logic              w_one_dir;
    logic              w_idle_act;
    logic              w_sel;
    logic              w_move;
    logic [CELL_W-1:0] w_cell;
    logic              w_occ;
    logic [IDX_W-1:0]  w_row_nxt, w_col_nxt;
    logic [PIX_W-1:0]  w_lx, w_ly, w_lc;

    // One step along an axis; edge behaviour follows WRAP
    function automatic logic [IDX_W-1:0] step(input logic [IDX_W-1:0] v, input logic dec);
        if (dec) return (v == 2'd0) ? (WRAP ? 2'd2 : 2'd0) : v - 2'd1;
        else     return (v >= 2'd2) ? (WRAP ? 2'd0 : 2'd2) : v + 2'd1;
    endfunction

    assign w_dir      = {i_btn_up, i_btn_down, i_btn_left, i_btn_right};
    assign w_one_dir  = (w_dir != 4'd0) && ((w_dir & (w_dir - 4'd1)) == 4'd0);
    assign w_idle_act = (r_state == ST_IDLE) && i_enable;
    // Select takes priority over direction pulses in the same cycle
    assign w_sel      = w_idle_act && i_btn_sel;
    assign w_move     = w_idle_act && !i_btn_sel && w_one_dir;
    assign w_cell     = cell_idx(r_row, r_col);
    assign w_occ      = i_occupied[w_cell];

    // Next cursor position from a single accepted direction pulse
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (w_move) begin
            if (i_btn_up)    w_row_nxt = step(r_row, 1'b1);
            if (i_btn_down)  w_row_nxt = step(r_row, 1'b0);
            if (i_btn_left)  w_col_nxt = step(r_col, 1'b1);
            if (i_btn_right) w_col_nxt = step(r_col, 1'b0);
        end
    end

    cell_anchor_lut u_lut (
        .i_row (r_row),
        .i_col (r_col),
        .o_x   (w_lx),
        .o_y   (w_ly),
        .o_c   (w_lc)
    );

    // Cursor registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row <= START_R;
            r_col <= START_C;
        end else begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
        end
    end

    // Anchors trail the cursor by one cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ax <= COL_X[START_COL];
            r_ay <= ROW_Y[START_ROW];
            r_ac <= ROW_C[START_ROW];
        end else begin
            r_ax <= w_lx;
            r_ay <= w_ly;
            r_ac <= w_lc;
        end
    end

    // Request FSM, captured cell index and reject pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_req_cell <= '0;
            r_reject   <= 1'b0;
        end else begin
            r_reject <= w_sel && w_occ;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel && !w_occ) begin
                        r_state    <= ST_REQ;
                        r_req_cell <= w_cell;
                    end
                end
                default: begin
                    if (req_if.req_ready) r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cur_row        = r_row;
    assign o_cur_col        = r_col;
    assign o_anchor_x       = r_ax;
    assign o_anchor_y       = r_ay;
    assign o_anchor_c       = r_ac;
    assign o_reject         = r_reject;
    assign req_if.req_valid = (r_state == ST_REQ);
    assign req_if.req_cell  = r_req_cell;

endmodule

// File: tb/tb_cursor_cell_ctrl.sv
// Directed bench: a WRAP=1 and a WRAP=0 instance share stimulus.
module tb_cursor_cell_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, up, dn, lf, rt, sel;
    logic [8:0] occ;

    logic [1:0] w_row, w_col, s_row, s_col;
    logic [9:0] w_ax, w_ay, w_ac, s_ax, s_ay, s_ac;
    logic       w_rej, s_rej;

    cursor_cell_ctrl_if w_if ();
    cursor_cell_ctrl_if s_if ();

    cursor_cell_ctrl #(.WRAP(1'b1), .START_ROW(1), .START_COL(1)) u_w (
        .i_clk(clk), .i_rst(rst), .i_enable(en),
        .i_btn_up(up), .i_btn_down(dn), .i_btn_left(lf), .i_btn_right(rt),
        .i_btn_sel(sel), .i_occupied(occ),
        .o_cur_row(w_row), .o_cur_col(w_col),
        .o_anchor_x(w_ax), .o_anchor_y(w_ay), .o_anchor_c(w_ac),
        .o_reject(w_rej), .req_if(w_if.master)
    );

    cursor_cell_ctrl #(.WRAP(1'b0), .START_ROW(1), .START_COL(1)) u_s (
        .i_clk(clk), .i_rst(rst), .i_enable(en),
        .i_btn_up(up), .i_btn_down(dn), .i_btn_left(lf), .i_btn_right(rt),
        .i_btn_sel(sel), .i_occupied(occ),
        .o_cur_row(s_row), .o_cur_col(s_col),
        .o_anchor_x(s_ax), .o_anchor_y(s_ay), .o_anchor_c(s_ac),
        .o_reject(s_rej), .req_if(s_if.master)
    );

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       u, d, l, r, s, rdy, en;
        logic [8:0] occ;
        int         row, col, ax, ay, ac, rv, rc, rj;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic u_i, d_i, l_i, r_i, s_i, rdy_i, en_i, input logic [8:0] occ_i);
        up = u_i; dn = d_i; lf = l_i; rt = r_i; sel = s_i;
        w_if.req_ready = rdy_i; s_if.req_ready = rdy_i;
        en = en_i; occ = occ_i;
        @(posedge clk); #1;
        up = 0; dn = 0; lf = 0; rt = 0; sel = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 1, 9'd0);
        rst = 0;
    endtask

    task automatic chk_w(input string tag, input int row, col, ax, ay, ac, rv);
        chk({tag, " row"}, w_row, row);
        chk({tag, " col"}, w_col, col);
        chk({tag, " ax"}, w_ax, ax);
        chk({tag, " ay"}, w_ay, ay);
        chk({tag, " ac"}, w_ac, ac);
        chk({tag, " req_valid"}, w_if.req_valid, rv);
    endtask

    initial begin
        rst = 1; en = 1; up = 0; dn = 0; lf = 0; rt = 0; sel = 0; occ = '0;
        w_if.req_ready = 0; s_if.req_ready = 0;

        //              u  d  l  r  s  rdy en occ        row col ax   ay   ac  rv rc rj
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 9'h000, 0,1, 305,221,271, 0,0,0};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 9'h000, 0,1, 305, 61,111, 0,0,0};
        tbl[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 9'h000, 0,0, 305, 61,111, 0,0,0};
        tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 9'h000, 0,2,  91, 61,111, 0,0,0};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 9'h000, 0,2, 518, 61,111, 0,0,0};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 9'h000, 0,0, 518, 61,111, 0,0,0};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 9'h000, 2,0,  91, 61,111, 0,0,0};
        tbl[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 9'h000, 2,0,  91,384,434, 0,0,0};
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 9'h000, 0,0,  91,384,434, 0,0,0};
        tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 9'h000, 1,0,  91, 61,111, 0,0,0};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 9'h000, 1,0,  91,221,271, 1,3,0};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 9'h000, 1,0,  91,221,271, 1,3,0};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 9'h000, 1,0,  91,221,271, 0,0,0};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 9'h000, 1,1,  91,221,271, 0,0,0};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 9'h010, 1,1, 305,221,271, 0,0,1};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 9'h010, 1,1, 305,221,271, 0,0,0};
        tbl[16] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 9'h000, 1,1, 305,221,271, 0,0,0};
        tbl[17] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 9'h000, 1,1, 305,221,271, 0,0,0};
        tbl[18] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 9'h000, 1,2, 305,221,271, 0,0,0};
        tbl[19] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 9'h000, 1,2, 518,221,271, 0,0,0};

        // Reset state, both instances
        do_reset();
        chk_w("reset w", 1, 1, 305, 221, 271, 0);
        chk("reset w req_cell", w_if.req_cell, 0);
        chk("reset w reject", w_rej, 0);
        chk("reset s row", s_row, 1);
        chk("reset s col", s_col, 1);
        chk("reset s ax", s_ax, 305);
        chk("reset s req_valid", s_if.req_valid, 0);

        // Table sweep on the wrapping instance
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].s,
                  tbl[i].rdy, tbl[i].en, tbl[i].occ);
            chk_w($sformatf("vec%0d", i), tbl[i].row, tbl[i].col,
                  tbl[i].ax, tbl[i].ay, tbl[i].ac, tbl[i].rv);
            chk($sformatf("vec%0d reject", i), w_rej, tbl[i].rj);
            if (tbl[i].rv == 1) chk($sformatf("vec%0d req_cell", i), w_if.req_cell, tbl[i].rc);
        end

        // Left edge: wrap vs saturate
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 9'd0);
        drive(0, 0, 1, 0, 0, 0, 1, 9'd0);
        drive(0, 0, 1, 0, 0, 0, 1, 9'd0);
        chk("edge w col", w_col, 2);
        chk("edge s col", s_col, 0);
        chk("edge s row", s_row, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 9'd0);
        chk("edge w ax", w_ax, 518);
        chk("edge s ax", s_ax, 91);
        // Bottom-right edge saturates on the WRAP=0 instance
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 1, 9'd0);
        drive(0, 1, 0, 0, 0, 0, 1, 9'd0);
        drive(0, 0, 0, 1, 0, 0, 1, 9'd0);
        drive(0, 0, 0, 1, 0, 0, 1, 9'd0);
        chk("sat s row", s_row, 2);
        chk("sat s col", s_col, 2);
        chk("wrap w row", w_row, 0);
        chk("wrap w col", w_col, 0);

        // Request at (2,2) held across ignored buttons and enable=0
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 1, 9'd0);
        drive(0, 0, 0, 1, 0, 0, 1, 9'd0);
        drive(0, 0, 0, 0, 1, 0, 1, 9'd0);
        chk("req valid", w_if.req_valid, 1);
        chk("req cell", w_if.req_cell, 8);
        for (int k = 0; k < 5; k++) begin
            drive(k == 0, k == 1, k == 2, k == 3, k == 4, 0, k != 2, 9'd0);
            chk($sformatf("hold%0d row", k), w_row, 2);
            chk($sformatf("hold%0d col", k), w_col, 2);
            chk($sformatf("hold%0d valid", k), w_if.req_valid, 1);
            chk($sformatf("hold%0d cell", k), w_if.req_cell, 8);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 9'd0);
        chk("ack valid", w_if.req_valid, 0);
        chk("ack row", w_row, 2);

        // Reset while a request is pending
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 1, 9'd0);
        drive(0, 0, 0, 0, 1, 0, 1, 9'd0);
        chk("pre-rst valid", w_if.req_valid, 1);
        chk("pre-rst cell", w_if.req_cell, 7);
        do_reset();
        chk_w("mid-rst", 1, 1, 305, 221, 271, 0);
        chk("mid-rst req_cell", w_if.req_cell, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 9'd0);
        drive(0, 0, 1, 0, 0, 0, 0, 9'd0);
        chk_w("disabled", 1, 1, 305, 221, 271, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cursor_cell_ctrl.md
Name: cursor_cell_ctrl

Overview:
- Board-cursor controller for the 3x3 TicTacToe grid on the 640x480 display.
- Holds the current cursor cell (row, col) and moves it on direction pulses.
- Performs the inverse of the position-to-cell mapping: converts the cell index to registered anchor pixels (x, y, centre-y) for the renderer.
- On select, issues a valid/ready move request to the game logic; occupied cells are rejected.

Parameters:
- WRAP, 1, 1: moves past an edge wrap to the opposite edge; 0: cursor saturates at the edge.
- START_ROW, 1, row index (0..2) loaded at reset.
- START_COL, 1, column index (0..2) loaded at reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  game active; when low, all button pulses are ignored
- btn_up  in  1  one-cycle pulse, debounced; row-1
- btn_down  in  1  one-cycle pulse; row+1
- btn_left  in  1  one-cycle pulse; col-1
- btn_right  in  1  one-cycle pulse; col+1
- btn_sel  in  1  one-cycle pulse; request a mark at the cursor cell
- occupied  in  9  bit (row*3+col) set = cell already marked
- cur_row  out  2  cursor row, 0..2
- cur_col  out  2  cursor column, 0..2
- anchor_x  out  10  column anchor pixel: col0=91, col1=305, col2=518
- anchor_y  out  10  row anchor pixel: row0=61, row1=221, row2=384
- anchor_c  out  10  row centre pixel: row0=111, row1=271, row2=434
- req_valid  out  1  move request pending
- req_cell  out  4  requested cell index 0..8; stable while req_valid=1
- req_ready  in  1  game logic accepts the request
- reject  out  1  one-cycle pulse: select hit an occupied cell

Behaviour:
- Reset values:
  - cur_row=START_ROW, cur_col=START_COL.
  - Anchors are those of the start cell; default (1,1) gives 305/221/271.
  - req_valid=0, req_cell=0, reject=0.
  - FSM in IDLE.
- FSM states:
  - IDLE: accepts moves and select.
  - REQ: req_valid=1; cursor frozen; all buttons ignored.
- Move handling, IDLE with enable=1:
  - Exactly one direction pulse: cur_row/cur_col update on the next edge.
  - Two or more direction pulses in the same cycle (incl. opposing): all ignored, no change.
  - Edge with WRAP=1: row 0 with up goes to 2; row 2 with down goes to 0; same rule for columns.
  - Edge with WRAP=0: value holds at 0 or 2.
  - Indices never take the value 3.
- Anchor outputs:
  - Registered from the cursor registers; valid 1 cycle after cur_row/cur_col change (2 cycles after the button pulse).
  - Must always equal the listed constants for the current indices.
- Select handling, IDLE with enable=1 and btn_sel=1:
  - btn_sel wins over any simultaneous direction pulse; the moves are dropped.
  - occupied[row*3+col]=1: reject=1 for exactly the next cycle; stay IDLE.
  - Otherwise: go to REQ next cycle; req_cell=row*3+col, captured at the select edge.
- Handshake:
  - In REQ, req_valid and req_cell hold until a cycle with req_ready=1.
  - On that edge, return to IDLE; req_valid=0 the next cycle.
  - req_ready while in IDLE has no effect.
- enable=0:
  - IDLE ignores all buttons.
  - A REQ already in flight still completes its handshake; enable does not cancel it.
- Reset mid-operation: rst=1 in any state returns to the reset values on the next edge; a pending request is dropped without handshake.
- Arithmetic: 2-bit indices; cell index = {row,1'b0}+row+col, 4 bits, max 8.

Decomposition:
- Shared package:
  - Anchor constants: COL_X[3], ROW_Y[3], ROW_C[3].
  - Cell-boundary constants 214/424 and 155/316, used by the existing position-to-cell mapper.
  - The FSM state enum.
- One natural sub-module: cell_anchor_lut, a pure index-to-pixel lookup; the parent registers its outputs.

Test Plan:
1. Reset with defaults -> cur=(1,1), anchor_x/y/c=305/221/271, req_valid=0; after up pulse -> cur=(0,1) next cycle, anchor_y=61, anchor_c=111 one cycle later.
2. WRAP=1, cursor (0,0), left pulse -> (0,2), anchor_x=518; WRAP=0 same stimulus -> stays (0,0), anchor_x=91.
3. Cursor (2,2), occupied=0, sel -> req_valid=1, req_cell=8; hold req_ready=0 for 5 cycles with direction pulses -> cursor and req_cell unchanged; req_ready=1 -> req_valid=0 next cycle.
4. Cursor (1,1), occupied[4]=1, sel -> reject high exactly 1 cycle, req_valid stays 0, FSM in IDLE.
5. Same-cycle right+left -> no change; same-cycle sel+down at (1,0) -> req_cell=3, cursor still (1,0).
6. rst asserted while req_valid=1 -> next cycle req_valid=0 and cursor=(1,1); enable=0 with pulses -> no change.
